// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM state and EX forwarding select encodings.
package hazard_pkg;

  typedef enum logic {
    HZ_RUN      = 1'b0,
    HZ_MEM_WAIT = 1'b1
  } hz_state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// Single-operand EX forwarding compare; the M-stage result is newer than W, so it wins.
module fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rd_m,
  input  logic [REG_W-1:0] rd_w,
  input  logic             regwrite_m,
  input  logic             regwrite_w,
  output fwd_sel_t         sel
);

  // x0 is hardwired to zero, so a write to it must never be forwarded.
  always_comb begin
    sel = FWD_RF;
    if (regwrite_m && (rd_m != '0) && (rd_m == rs)) begin
      sel = FWD_MEM;
    end else if (regwrite_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipe with data-memory wait and timeout.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W       = 5,
  parameter int MEM_TIMEOUT = 255
`ifdef HAZARD_PERF_EN
  ,
  parameter int CNT_W       = 32
`endif
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [REG_W-1:0] rs1_d,
  input  logic [REG_W-1:0] rs2_d,
  input  logic [REG_W-1:0] rs1_e,
  input  logic [REG_W-1:0] rs2_e,
  input  logic [REG_W-1:0] rd_e,
  input  logic [REG_W-1:0] rd_m,
  input  logic [REG_W-1:0] rd_w,
  input  logic             memread_e,
  input  logic             regwrite_m,
  input  logic             regwrite_w,
  input  logic             branch_taken_e,
  input  logic             dmem_req_m,
  input  logic             dmem_ack,
  output logic             en_f,
  output logic             en_d,
  output logic             en_e,
  output logic             en_m,
  output logic             en_w,
  output logic             srst_d_n,
  output logic             srst_e_n,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic             mem_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  hz_state_t       state;
  logic [TO_W-1:0] wait_cnt;
  logic            timeout;
  logic            mem_stall;
  logic            load_use;
  logic            branch;
  fwd_sel_t        fwd_a;
  fwd_sel_t        fwd_b;

  assign timeout = (state == HZ_MEM_WAIT) && !dmem_ack && (wait_cnt == TO_LAST);

  // A request acked in its own cycle never stalls; the timeout cycle releases the pipe like an ack.
  always_comb begin
    mem_stall = 1'b0;
    if (state == HZ_RUN) begin
      mem_stall = dmem_req_m && !dmem_ack;
    end else begin
      mem_stall = !dmem_ack && !timeout;
    end
  end

  assign load_use = memread_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
  assign branch   = branch_taken_e;

  // Clears are suppressed under a memory stall because the registers honour clear over enable.
  always_comb begin
    en_f     = 1'b1;
    en_d     = 1'b1;
    srst_d_n = 1'b1;
    srst_e_n = 1'b1;
    if (mem_stall) begin
      en_f = 1'b0;
      en_d = 1'b0;
    end else if (branch) begin
      srst_d_n = 1'b0;
      srst_e_n = 1'b0;
    end else if (load_use) begin
      en_f     = 1'b0;
      en_d     = 1'b0;
      srst_e_n = 1'b0;
    end
  end

  assign en_e    = !mem_stall;
  assign en_m    = !mem_stall;
  assign en_w    = !mem_stall;
  assign mem_err = timeout;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state    <= HZ_RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        HZ_RUN: begin
          if (dmem_req_m && !dmem_ack) begin
            state    <= HZ_MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        HZ_MEM_WAIT: begin
          if (dmem_ack || timeout) begin
            state <= HZ_RUN;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= HZ_RUN;
      endcase
    end
  end

  fwd_unit #(.REG_W(REG_W)) u_fwd_a (
    .rs         (rs1_e),
    .rd_m       (rd_m),
    .rd_w       (rd_w),
    .regwrite_m (regwrite_m),
    .regwrite_w (regwrite_w),
    .sel        (fwd_a)
  );

  fwd_unit #(.REG_W(REG_W)) u_fwd_b (
    .rs         (rs2_e),
    .rd_m       (rd_m),
    .rd_w       (rd_w),
    .regwrite_m (regwrite_m),
    .regwrite_w (regwrite_w),
    .sel        (fwd_b)
  );

  assign fwd_a_e = fwd_a;
  assign fwd_b_e = fwd_b;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!en_d) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (!srst_d_n || !srst_e_n) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table for combinational policy plus
// hand-written sequences for load-use, memory wait, timeout and reset-in-wait.
module tb_pipeline_hazard_ctrl;

  localparam logic [11:0] ALL_RUN    = 12'b11111_11_00_00_0;
  localparam logic [11:0] MEM_STALL  = 12'b00000_11_00_00_0;
  localparam logic [11:0] ERR_RESUME = 12'b11111_11_00_00_1;

  logic       clk;
  logic       arst;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       memread_e, regwrite_m, regwrite_w, branch_taken_e;
  logic       dmem_req_m, dmem_ack;
  logic       en_f, en_d, en_e, en_m, en_w, srst_d_n, srst_e_n, mem_err;
  logic [1:0] fwd_a_e, fwd_b_e;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic        memread_e, regwrite_m, regwrite_w, branch_taken_e;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[12];

  pipeline_hazard_ctrl #(.REG_W(5), .MEM_TIMEOUT(4)) dut (
    .clk            (clk),
    .arst           (arst),
    .rs1_d          (rs1_d),
    .rs2_d          (rs2_d),
    .rs1_e          (rs1_e),
    .rs2_e          (rs2_e),
    .rd_e           (rd_e),
    .rd_m           (rd_m),
    .rd_w           (rd_w),
    .memread_e      (memread_e),
    .regwrite_m     (regwrite_m),
    .regwrite_w     (regwrite_w),
    .branch_taken_e (branch_taken_e),
    .dmem_req_m     (dmem_req_m),
    .dmem_ack       (dmem_ack),
    .en_f           (en_f),
    .en_d           (en_d),
    .en_e           (en_e),
    .en_m           (en_m),
    .en_w           (en_w),
    .srst_d_n       (srst_d_n),
    .srst_e_n       (srst_e_n),
    .fwd_a_e        (fwd_a_e),
    .fwd_b_e        (fwd_b_e),
    .mem_err        (mem_err)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(string name, logic [4:0] r1d, logic [4:0] r2d, logic [4:0] r1e,
                                 logic [4:0] r2e, logic [4:0] rde, logic [4:0] rdm, logic [4:0] rdw,
                                 logic mr, logic rwm, logic rww, logic br, logic [11:0] exp);
    vec_t v;
    v.name = name;
    v.rs1_d = r1d; v.rs2_d = r2d; v.rs1_e = r1e; v.rs2_e = r2e;
    v.rd_e = rde; v.rd_m = rdm; v.rd_w = rdw;
    v.memread_e = mr; v.regwrite_m = rwm; v.regwrite_w = rww; v.branch_taken_e = br;
    v.exp = exp;
    return v;
  endfunction

  task automatic clearInputs();
    rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0;
    rd_e = '0; rd_m = '0; rd_w = '0;
    memread_e = 1'b0; regwrite_m = 1'b0; regwrite_w = 1'b0; branch_taken_e = 1'b0;
    dmem_req_m = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    rs1_d = v.rs1_d; rs2_d = v.rs2_d; rs1_e = v.rs1_e; rs2_e = v.rs2_e;
    rd_e = v.rd_e; rd_m = v.rd_m; rd_w = v.rd_w;
    memread_e = v.memread_e; regwrite_m = v.regwrite_m; regwrite_w = v.regwrite_w;
    branch_taken_e = v.branch_taken_e;
    dmem_req_m = 1'b0; dmem_ack = 1'b0;
  endtask

  // Packed as {en_f,en_d,en_e,en_m,en_w,srst_d_n,srst_e_n,fwd_a_e,fwd_b_e,mem_err}.
  task automatic checkOutput(input string name, input logic [11:0] exp);
    logic [11:0] act;
    act = {en_f, en_d, en_e, en_m, en_w, srst_d_n, srst_e_n, fwd_a_e, fwd_b_e, mem_err};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = mkVec("idle",          0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ALL_RUN);
    vecs[1]  = mkVec("fwd_a_mem",     0, 0, 5, 0, 0, 5, 5, 0, 1, 1, 0, 12'b11111_11_10_00_0);
    vecs[2]  = mkVec("fwd_a_wb",      0, 0, 5, 0, 0, 0, 5, 0, 1, 1, 0, 12'b11111_11_01_00_0);
    vecs[3]  = mkVec("fwd_a_mem_b_wb",0, 0, 4, 3, 0, 4, 3, 0, 1, 1, 0, 12'b11111_11_10_01_0);
    vecs[4]  = mkVec("fwd_x0",        0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, ALL_RUN);
    vecs[5]  = mkVec("fwd_no_wr",     0, 0, 6, 6, 0, 6, 6, 0, 0, 0, 0, ALL_RUN);
    vecs[6]  = mkVec("load_use_rs2",  0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 0, 12'b00111_10_00_00_0);
    vecs[7]  = mkVec("load_x0",       0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, ALL_RUN);
    vecs[8]  = mkVec("no_load",       7, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, ALL_RUN);
    vecs[9]  = mkVec("branch",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12'b11111_00_00_00_0);
    vecs[10] = mkVec("branch_vs_lu",  9, 0, 0, 0, 9, 0, 0, 1, 0, 0, 1, 12'b11111_00_00_00_0);
    vecs[11] = mkVec("lu_rs1_fwd_wb", 2, 0, 8, 0, 2, 0, 8, 1, 0, 1, 0, 12'b00111_10_01_00_0);

    clearInputs();
    arst = 1'b0;
    #12;
    checkOutput("reset_state", ALL_RUN);
    nextCycle();
    arst = 1'b1;
    #2;
    checkOutput("after_reset", ALL_RUN);

    for (int i = 0; i < 12; i++) begin
      nextCycle();
      applyStimulus(vecs[i]);
      #2;
      checkOutput(vecs[i].name, vecs[i].exp);
    end

    // Load-use stall is one cycle, then the dependent instruction in E forwards from M.
    nextCycle();
    clearInputs();
    memread_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
    #2;
    checkOutput("lu_seq_stall", 12'b00111_10_00_00_0);
    nextCycle();
    clearInputs();
    rd_m = 5'd7; regwrite_m = 1'b1; rs2_e = 5'd7;
    #2;
    checkOutput("lu_seq_fwd", 12'b11111_11_00_10_0);

    // Memory access acked 3 cycles after the request; branch/load-use must not clear during the stall.
    nextCycle();
    clearInputs();
    dmem_req_m = 1'b1; branch_taken_e = 1'b1;
    #2;
    checkOutput("mem_req", MEM_STALL);
    nextCycle();
    dmem_req_m = 1'b1;
    #2;
    checkOutput("mem_wait1", MEM_STALL);
    nextCycle();
    clearInputs();
    memread_e = 1'b1; rd_e = 5'd3; rs1_d = 5'd3;
    #2;
    checkOutput("mem_wait2_lu", MEM_STALL);
    nextCycle();
    clearInputs();
    dmem_ack = 1'b1;
    #2;
    checkOutput("mem_ack", ALL_RUN);
    nextCycle();
    clearInputs();
    #2;
    checkOutput("mem_back_run", ALL_RUN);
    nextCycle();
    dmem_req_m = 1'b1; dmem_ack = 1'b1;
    #2;
    checkOutput("mem_same_cycle_ack", ALL_RUN);
    nextCycle();
    clearInputs();
    #2;
    checkOutput("mem_same_cycle_after", ALL_RUN);

    // Timeout with MEM_TIMEOUT=4: request cycle, three silent wait cycles, error on the fourth.
    nextCycle();
    dmem_req_m = 1'b1;
    #2;
    checkOutput("to_req", MEM_STALL);
    for (int i = 1; i <= 3; i++) begin
      nextCycle();
      dmem_req_m = 1'b0;
      #2;
      checkOutput($sformatf("to_wait%0d", i), MEM_STALL);
    end
    nextCycle();
    #2;
    checkOutput("to_err", ERR_RESUME);
    nextCycle();
    #2;
    checkOutput("to_resume", ALL_RUN);

    // Reset during MEM_WAIT drops the outstanding wait at once.
    nextCycle();
    dmem_req_m = 1'b1;
    #2;
    checkOutput("rst_req", MEM_STALL);
    nextCycle();
    clearInputs();
    #2;
    checkOutput("rst_in_wait", MEM_STALL);
    #1;
    arst = 1'b0;
    #1;
    checkOutput("rst_async", ALL_RUN);
    nextCycle();
    arst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      nextCycle();
      #2;
      checkOutput($sformatf("rst_after%0d", i), ALL_RUN);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
